// File: rtl/dma_pkg.sv
// Shared DMA channel definitions: default datapath widths, APB address stride
// and the write-master state encoding.
package dma_pkg;

    localparam int DMA_ADDR_WIDTH = 32;
    localparam int DMA_DATA_WIDTH = 32;
    localparam int DMA_LEN_WIDTH  = 16;

    localparam int APB_ADDR_INC   = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_SETUP  = 3'd2;
    localparam state_t ST_ACCESS = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/dma_apb_wr_master.sv
// Per-channel APB write master: pops FIFO words and writes them to APB.
// Optional ACCESS-phase timeout is compiled in with DMA_APB_WR_TIMEOUT_EN.
module dma_apb_wr_master
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH     = DMA_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DMA_DATA_WIDTH,
    parameter int LEN_WIDTH      = DMA_LEN_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  xfer_len,
    input  logic                  addr_inc,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  words_left
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  inc_q;
    logic                  pop;
    logic                  timeout;

    // Abort wins over a same-cycle pop so no word is lost from the FIFO.
    assign pop       = (state == ST_FETCH) && !fifo_empty && !abort;
    assign fifo_r_en = pop;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign pwrite    = psel;

`ifdef DMA_APB_WR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    assign timeout = (state == ST_ACCESS) && !pready
                     && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !pready && !timeout) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end
`else
    // Without the timeout, ACCESS waits on pready indefinitely.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            inc_q      <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            err        <= 1'b0;
            words_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr   <= dst_addr;
                        inc_q      <= addr_inc;
                        err        <= 1'b0;
                        words_left <= xfer_len;
                        state      <= (xfer_len == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        state <= ST_DONE;
                    end else if (!fifo_empty) begin
                        pwdata <= fifo_rdata;
                        paddr  <= cur_addr;
                        psel   <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            words_left <= words_left - LEN_WIDTH'(1);
                            if (inc_q) begin
                                cur_addr <= cur_addr + ADDR_WIDTH'(APB_ADDR_INC);
                            end
                            state <= (words_left == LEN_WIDTH'(1)) ? ST_DONE : ST_FETCH;
                        end
                    end else if (timeout) begin
                        err     <= 1'b1;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
